// File: rtl/fifo_8x32.sv
`default_nettype none
// ============================================================================
// Module      : fifo_8x32
// Description : 8-entry x 32-bit synchronous FIFO with registered
//               request/ack/error handshakes. Optional almost_full and
//               almost_empty outputs when FIFO_ALMOST_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_8x32 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] d_in,
   output logic [31:0] d_out,
   output logic        full,
   output logic        empty,
   output logic        wr_ack,
   output logic        wr_err,
   output logic        rd_ack,
   output logic        rd_err,
   output logic [3:0]  data_count
`ifdef FIFO_ALMOST_FLAGS_EN
   ,
   output logic        almost_full,
   output logic        almost_empty
`endif
);

   typedef enum logic [2:0] {
      ST_INIT     = 3'b000,
      ST_NO_OP    = 3'b001,
      ST_WRITE    = 3'b010,
      ST_WR_ERROR = 3'b011,
      ST_READ     = 3'b100,
      ST_RD_ERROR = 3'b101
   } state_t;

   localparam logic [3:0] c_DEPTH = 4'd8;

   state_t       r_state;
   state_t       w_next;
   logic [31:0]  r_mem [0:7];
   logic [2:0]   r_wr_ptr;
   logic [2:0]   r_rd_ptr;
   logic [3:0]   r_count;
   logic [31:0]  r_dout;
   logic         w_full;
   logic         w_empty;

   assign w_full  = (r_count == c_DEPTH);
   assign w_empty = (r_count == 4'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state ignores the current state for all legal encodings; the
   // illegal ones are forced back to INIT without touching the datapath.
   always_comb begin
      w_next = ST_NO_OP;
      case (r_state)
         ST_INIT, ST_NO_OP, ST_WRITE, ST_WR_ERROR, ST_READ, ST_RD_ERROR: begin
            if (wr_en && !rd_en) begin
               w_next = w_full ? ST_WR_ERROR : ST_WRITE;
            end else if (!wr_en && rd_en) begin
               w_next = w_empty ? ST_RD_ERROR : ST_READ;
            end else begin
               w_next = ST_NO_OP;
            end
         end
         default: w_next = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= 3'd0;
         r_rd_ptr <= 3'd0;
         r_count  <= 4'd0;
         r_dout   <= 32'd0;
      end else begin
         r_dout <= 32'd0;
         case (w_next)
            ST_WRITE: begin
               r_wr_ptr <= r_wr_ptr + 3'd1;
               r_count  <= r_count + 4'd1;
            end
            ST_READ: begin
               r_dout   <= r_mem[r_rd_ptr];
               r_rd_ptr <= r_rd_ptr + 3'd1;
               r_count  <= r_count - 4'd1;
            end
            default: begin
               r_wr_ptr <= r_wr_ptr;
            end
         endcase
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_next == ST_WRITE) begin
         r_mem[r_wr_ptr] <= d_in;
      end
   end

   assign d_out      = r_dout;
   assign wr_ack     = (r_state == ST_WRITE);
   assign wr_err     = (r_state == ST_WR_ERROR);
   assign rd_ack     = (r_state == ST_READ);
   assign rd_err     = (r_state == ST_RD_ERROR);
   assign full       = w_full;
   assign empty      = w_empty;
   assign data_count = r_count;

`ifdef FIFO_ALMOST_FLAGS_EN
   assign almost_full  = (r_count >= 4'd7);
   assign almost_empty = (r_count <= 4'd1);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_8x32.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_8x32
// Description : Directed self-checking bench for fifo_8x32 with a data
//               scoreboard queue. Honours FIFO_ALMOST_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_8x32;

   logic        clk;
   logic        reset_n;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] d_in;
   logic [31:0] d_out;
   logic        full;
   logic        empty;
   logic        wr_ack;
   logic        wr_err;
   logic        rd_ack;
   logic        rd_err;
   logic [3:0]  data_count;
`ifdef FIFO_ALMOST_FLAGS_EN
   logic        almost_full;
   logic        almost_empty;
`endif

   int          n_total;
   int          n_pass;
   int          m_cnt;
   logic [31:0] sb [$];

   fifo_8x32 u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .d_in       (d_in),
      .d_out      (d_out),
      .full       (full),
      .empty      (empty),
      .wr_ack     (wr_ack),
      .wr_err     (wr_err),
      .rd_ack     (rd_ack),
      .rd_err     (rd_err),
      .data_count (data_count)
`ifdef FIFO_ALMOST_FLAGS_EN
      ,
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Flags, count and data that must be visible for the current model state.
   task automatic chk_all(input string tag, input logic ewa, input logic ewe,
                          input logic era, input logic ere, input logic [31:0] edout);
      chk({tag, ".wr_ack"}, {31'd0, wr_ack}, {31'd0, ewa});
      chk({tag, ".wr_err"}, {31'd0, wr_err}, {31'd0, ewe});
      chk({tag, ".rd_ack"}, {31'd0, rd_ack}, {31'd0, era});
      chk({tag, ".rd_err"}, {31'd0, rd_err}, {31'd0, ere});
      chk({tag, ".d_out"}, d_out, edout);
      chk({tag, ".count"}, {28'd0, data_count}, m_cnt);
      chk({tag, ".full"}, {31'd0, full}, {31'd0, (m_cnt == 8)});
      chk({tag, ".empty"}, {31'd0, empty}, {31'd0, (m_cnt == 0)});
`ifdef FIFO_ALMOST_FLAGS_EN
      chk({tag, ".afull"}, {31'd0, almost_full}, {31'd0, (m_cnt >= 7)});
      chk({tag, ".aempty"}, {31'd0, almost_empty}, {31'd0, (m_cnt <= 1)});
`endif
   endtask

   task automatic op(input string tag, input logic w, input logic r, input logic [31:0] d);
      logic        ewa, ewe, era, ere;
      logic [31:0] edout;
      ewa   = w && !r && (m_cnt < 8);
      ewe   = w && !r && (m_cnt == 8);
      era   = !w && r && (m_cnt > 0);
      ere   = !w && r && (m_cnt == 0);
      edout = 32'd0;
      if (ewa) begin
         sb.push_back(d);
         m_cnt++;
      end
      if (era) begin
         edout = sb.pop_front();
         m_cnt--;
      end
      @(negedge clk);
      wr_en = w;
      rd_en = r;
      d_in  = d;
      @(posedge clk);
      #1;
      chk_all(tag, ewa, ewe, era, ere, edout);
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      m_cnt   = 0;
      reset_n = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      d_in    = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 5; i++) op("idle", 1'b0, 1'b0, 32'hFFFF_FFFF);

      for (int i = 1; i <= 8; i++) op("fill", 1'b1, 1'b0, 32'h1111_1111 * i);
      op("wr_over", 1'b1, 1'b0, 32'hDEAD_BEEF);
      op("idle_full", 1'b0, 1'b0, 32'd0);

      for (int i = 1; i <= 8; i++) op("drain", 1'b0, 1'b1, 32'd0);
      op("rd_under", 1'b0, 1'b1, 32'd0);

      for (int i = 0; i < 6; i++) op("wrap_w6", 1'b1, 1'b0, $urandom);
      for (int i = 0; i < 6; i++) op("wrap_r6", 1'b0, 1'b1, 32'd0);
      for (int i = 0; i < 5; i++) op("wrap_w5", 1'b1, 1'b0, $urandom);
      for (int i = 0; i < 5; i++) op("wrap_r5", 1'b0, 1'b1, 32'd0);

      op("raw_w", 1'b1, 1'b0, 32'hCAFE_F00D);
      op("raw_r", 1'b0, 1'b1, 32'd0);

      for (int i = 0; i < 3; i++) op("pre_both", 1'b1, 1'b0, 32'hA000_0000 + i);
      op("both", 1'b1, 1'b1, 32'h5555_5555);
      op("after_both", 1'b0, 1'b1, 32'd0);

      for (int i = 0; i < 3; i++) op("pre_rst", 1'b1, 1'b0, 32'hB000_0000 + i);
      op("pre_rst_rd", 1'b0, 1'b1, 32'd0);

      // Asynchronous reset between clock edges, with rd_ack and d_out live.
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      sb.delete();
      m_cnt = 0;
      chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      op("post_rst_rd", 1'b0, 1'b1, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
